ram_sp_ctrl: RTL
================

RAM_SP_CTRL -- requirements
Module: ram_sp_ctrl

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 64: RAM word count.
REQ-002 SHALL have parameter BYTE_WIDTH, default 8: bits per byte lane.
REQ-003 SHALL have parameter BYTE_NUM, default 4: byte lanes per word.
REQ-004 SHALL have parameter RD_LATENCY, default 6: cycles from ram_en_o high (read) to ram_data_i valid; legal range 1..32.
REQ-005 SHALL have parameter ADDR_WIDTH, default $clog2(MEM_DEPTH), and MEM_WIDTH, default BYTE_WIDTH*BYTE_NUM.
REQ-006 SHALL have derived constant FIFO_DEPTH = RD_LATENCY+2.
REQ-007 Ports (name direction width meaning); one clock, clk_i; reset rst_i is asynchronous, active-high:
- clk_i  in  1  clock
- rst_i  in  1  async active-high reset
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command accepted when high with valid
- cmd_we_i  in  BYTE_NUM  byte write strobes; all-zero = read
- cmd_addr_i  in  ADDR_WIDTH  word address
- cmd_data_i  in  MEM_WIDTH  write data
- rsp_valid_o  out  1  read data valid
- rsp_ready_i  in  1  consumer ready
- rsp_data_o  out  MEM_WIDTH  read data
- ram_en_o  out  1  RAM enable
- ram_wr_en_o  out  BYTE_NUM  RAM byte write enables
- ram_addr_o  out  ADDR_WIDTH  RAM address
- ram_data_o  out  MEM_WIDTH  RAM write data
- ram_data_i  in  MEM_WIDTH  RAM read data

Function
REQ-008 Command handshake SHALL occur on a rising clk_i edge with cmd_valid_i & cmd_ready_o.
REQ-009 ram_en_o SHALL equal cmd_valid_i & cmd_ready_o combinationally; ram_wr_en_o = cmd_we_i gated by ram_en_o; ram_addr_o = cmd_addr_i; ram_data_o = cmd_data_i.
REQ-010 Occupancy counter occ (0..FIFO_DEPTH) SHALL increment on read handshake, decrement on response handshake, hold when both or neither occur.
REQ-011 cmd_ready_o SHALL be registered-derived: high iff occ < FIFO_DEPTH; no combinational path from rsp_ready_i or cmd_valid_i to cmd_ready_o.
REQ-012 When cmd_ready_o is low, reads and writes SHALL both be stalled (strict in-order issue).
REQ-013 Writes SHALL generate no response and SHALL not affect occ.
REQ-014 A RD_LATENCY-bit tag shift register SHALL record each read issue; when the tag exits, ram_data_i SHALL be pushed into the response FIFO that same edge.
REQ-015 Response FIFO SHALL be show-ahead, FIFO_DEPTH entries, in order; rsp_valid_o high iff non-empty; rsp_data_o = head entry.
REQ-016 Push and pop in the same cycle SHALL both take effect; FIFO SHALL never overflow by construction of occ.
REQ-017 rsp_data_o SHALL stay stable while rsp_valid_o high and rsp_ready_i low.
REQ-018 With rsp_ready_i held high, back-to-back reads SHALL sustain one command per cycle indefinitely.
REQ-019 Read latency cmd handshake -> rsp_valid_o SHALL be RD_LATENCY+1 cycles.
REQ-020 Read after write to same address SHALL return the written data (RAM ordering, no forwarding needed).
REQ-021 occ, FIFO pointers and counts SHALL wrap modulo their ranges without aliasing full/empty.

Reset
REQ-022 rst_i high SHALL asynchronously clear occ, tag shift register, FIFO pointers; cmd_ready_o=1, rsp_valid_o=0, rsp_data_o=0.
REQ-023 Reads in flight at reset SHALL be discarded; returning ram_data_i SHALL not be pushed.
REQ-024 ram_en_o and ram_wr_en_o SHALL be 0 while rst_i is high.

Configuration
REQ-025 With macro RAM_SP_CTRL_STATS_EN defined, SHALL add outputs rd_cnt_o[31:0], wr_cnt_o[31:0], stall_cnt_o[31:0]: saturating counts of read handshakes, write handshakes, cycles with cmd_valid_i & !cmd_ready_o; reset to 0.
REQ-026 Without RAM_SP_CTRL_STATS_EN these ports and counters SHALL be absent; other behaviour identical.

Verification
REQ-027 Write 0xDEADBEEF strobes 4'hF addr 5, then read addr 5 -> rsp_data_o=0xDEADBEEF exactly 7 cycles after read handshake.
REQ-028 Write 0x11223344 then strobe 4'b0010 data 0x0000AA00 to addr 3; read -> 0x1122AA44.
REQ-029 rsp_ready_i=0, 20 consecutive reads -> exactly 8 accepted, cmd_ready_o low; release -> 8 in-order responses, then issue resumes.
REQ-030 rsp_ready_i=1, 100 reads addr 0..99 mod 64 -> one accept per cycle, responses in address order, no gaps.
REQ-031 Assert rst_i with 3 reads in flight -> rsp_valid_o never asserts for them; next read returns correct data.
REQ-032 With RAM_SP_CTRL_STATS_EN, 10 writes, 12 reads, 4 stalled cycles -> wr_cnt_o=10, rd_cnt_o=12, stall_cnt_o=4.

Source files
------------

// File: rtl/ram_sp_ctrl.sv
// -----------------------------------------------------------------------------
// ram_sp_ctrl
// Controller for a single-port synchronous RAM with a fixed read latency.
// Commands (reads and byte-masked writes) are passed straight to the RAM when
// accepted. Read data returning from the RAM is captured into an in-order,
// show-ahead response FIFO. An occupancy counter reserves a FIFO slot for
// every issued read, so the FIFO can never overflow and the command side
// stalls once all slots are reserved.
//
// Ports:
//   clk_i        clock
//   rst_i        asynchronous active-high reset
//   cmd_valid_i  command valid
//   cmd_ready_o  command accepted when high together with cmd_valid_i
//   cmd_we_i     byte write strobes, all-zero means read
//   cmd_addr_i   word address
//   cmd_data_i   write data
//   rsp_valid_o  read data valid (FIFO non-empty)
//   rsp_ready_i  consumer ready
//   rsp_data_o   read data (FIFO head)
//   ram_en_o     RAM enable
//   ram_wr_en_o  RAM byte write enables
//   ram_addr_o   RAM address
//   ram_data_o   RAM write data
//   ram_data_i   RAM read data
//
// Optional feature: define RAM_SP_CTRL_STATS_EN to add saturating statistics
// outputs rd_cnt_o, wr_cnt_o and stall_cnt_o (32 bits each).
// -----------------------------------------------------------------------------
module ram_sp_ctrl #(
   parameter int MEM_DEPTH  = 64,
   parameter int BYTE_WIDTH = 8,
   parameter int BYTE_NUM   = 4,
   parameter int RD_LATENCY = 6,
   parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
   parameter int MEM_WIDTH  = BYTE_WIDTH * BYTE_NUM
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  cmd_valid_i,
   output logic                  cmd_ready_o,
   input  logic [BYTE_NUM-1:0]   cmd_we_i,
   input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
   input  logic [MEM_WIDTH-1:0]  cmd_data_i,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic [MEM_WIDTH-1:0]  rsp_data_o,
   output logic                  ram_en_o,
   output logic [BYTE_NUM-1:0]   ram_wr_en_o,
   output logic [ADDR_WIDTH-1:0] ram_addr_o,
   output logic [MEM_WIDTH-1:0]  ram_data_o,
   input  logic [MEM_WIDTH-1:0]  ram_data_i
`ifdef RAM_SP_CTRL_STATS_EN
  ,output logic [31:0]           rd_cnt_o,
   output logic [31:0]           wr_cnt_o,
   output logic [31:0]           stall_cnt_o
`endif
);

   localparam int FIFO_DEPTH = RD_LATENCY + 2;
   localparam int OCC_W      = $clog2(FIFO_DEPTH + 1);
   localparam int PTR_W      = $clog2(FIFO_DEPTH);

   localparam logic [OCC_W-1:0] OCC_MAX  = OCC_W'(FIFO_DEPTH);
   localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
   localparam logic [OCC_W-1:0] OCC_ZERO = OCC_W'(0);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(0);

   // FIFO depth need not be a power of two, so pointers wrap explicitly.
   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      if (p == PTR_LAST) begin
         return PTR_ZERO;
      end else begin
         return p + PTR_ONE;
      end
   endfunction

   logic                  cmd_hs_s;
   logic                  rd_hs_s;
   logic                  push_s;
   logic                  pop_s;
   logic [OCC_W-1:0]      occ_r;
   logic [OCC_W-1:0]      occ_next_s;
   logic                  ready_r;
   logic [RD_LATENCY-1:0] tag_r;
   logic [RD_LATENCY-1:0] tag_next_s;
   logic [MEM_WIDTH-1:0]  fifo_mem_r [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr_r;
   logic [PTR_W-1:0]      rd_ptr_r;
   logic [OCC_W-1:0]      fifo_cnt_r;

   // rst_i gates the handshake so the RAM sees no enable while in reset.
   assign cmd_hs_s    = cmd_valid_i & ready_r & ~rst_i;
   assign rd_hs_s     = cmd_hs_s & (cmd_we_i == {BYTE_NUM{1'b0}});
   assign push_s      = tag_r[RD_LATENCY-1];
   assign pop_s       = (fifo_cnt_r != OCC_ZERO) & rsp_ready_i;

   assign cmd_ready_o = ready_r;
   assign ram_en_o    = cmd_hs_s;
   assign ram_wr_en_o = cmd_we_i & {BYTE_NUM{cmd_hs_s}};
   assign ram_addr_o  = cmd_addr_i;
   assign ram_data_o  = cmd_data_i;
   assign rsp_valid_o = (fifo_cnt_r != OCC_ZERO);
   assign rsp_data_o  = fifo_mem_r[rd_ptr_r];

   // Next occupancy: reads reserve a slot, response pops release one.
   always_comb begin
      occ_next_s = occ_r;
      if (rd_hs_s && !pop_s) begin
         occ_next_s = occ_r + OCC_ONE;
      end else if (!rd_hs_s && pop_s) begin
         occ_next_s = occ_r - OCC_ONE;
      end else begin
         occ_next_s = occ_r;
      end
   end

   // Next tag vector: shift toward the MSB, new read issue enters at bit 0.
   always_comb begin
      tag_next_s    = tag_r << 1;
      tag_next_s[0] = rd_hs_s;
   end

   // Occupancy, registered ready flag and read-issue tag pipeline.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         occ_r   <= OCC_ZERO;
         ready_r <= 1'b1;
         tag_r   <= {RD_LATENCY{1'b0}};
      end else begin
         occ_r   <= occ_next_s;
         ready_r <= (occ_next_s < OCC_MAX);
         tag_r   <= tag_next_s;
      end
   end

   // Response FIFO pointers and fill count.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_r   <= PTR_ZERO;
         rd_ptr_r   <= PTR_ZERO;
         fifo_cnt_r <= OCC_ZERO;
      end else begin
         if (push_s) begin
            wr_ptr_r <= next_ptr(wr_ptr_r);
         end
         if (pop_s) begin
            rd_ptr_r <= next_ptr(rd_ptr_r);
         end
         if (push_s && !pop_s) begin
            fifo_cnt_r <= fifo_cnt_r + OCC_ONE;
         end else if (!push_s && pop_s) begin
            fifo_cnt_r <= fifo_cnt_r - OCC_ONE;
         end
      end
   end

   // Response FIFO storage; cleared so rsp_data_o reads zero out of reset.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_mem_r[i] <= {MEM_WIDTH{1'b0}};
         end
      end else if (push_s) begin
         fifo_mem_r[wr_ptr_r] <= ram_data_i;
      end
   end

`ifdef RAM_SP_CTRL_STATS_EN
   logic        wr_hs_s;
   logic        stall_s;
   logic [31:0] rd_cnt_r;
   logic [31:0] wr_cnt_r;
   logic [31:0] stall_cnt_r;

   assign wr_hs_s     = cmd_hs_s & (cmd_we_i != {BYTE_NUM{1'b0}});
   assign stall_s     = cmd_valid_i & ~ready_r;
   assign rd_cnt_o    = rd_cnt_r;
   assign wr_cnt_o    = wr_cnt_r;
   assign stall_cnt_o = stall_cnt_r;

   // Saturating event counters for reads, writes and stalled cycles.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_cnt_r    <= 32'd0;
         wr_cnt_r    <= 32'd0;
         stall_cnt_r <= 32'd0;
      end else begin
         if (rd_hs_s && (rd_cnt_r != 32'hFFFF_FFFF)) begin
            rd_cnt_r <= rd_cnt_r + 32'd1;
         end
         if (wr_hs_s && (wr_cnt_r != 32'hFFFF_FFFF)) begin
            wr_cnt_r <= wr_cnt_r + 32'd1;
         end
         if (stall_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
         end
      end
   end
`endif

endmodule
